interrupt_controller: RTL and testbench

Prioritised interrupt controller that sits directly upstream of the CPU core's `int_req`/`int_ack` handshake. It collects up to eight asynchronous external interrupt lines, synchronises them, and latches edge events into a pending register. It arbitrates by fixed priority and drives a single four-phase request/acknowledge handshake toward the execution unit. Mask, mode and pending state are exposed through a small register port that the memory/IO mux maps into the data address space.

---
 rtl/interrupt_controller_if.sv | 31 +++
 rtl/interrupt_controller.sv | 134 +++++++++++++
 tb/tb_interrupt_controller.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/interrupt_controller_if.sv
// Register port and int_req/int_ack handshake between the
// interrupt controller (slave) and the core / IO mux (master).
interface interrupt_controller_if #(
  parameter int DATA_BITS = 8
);
  logic                 reg_wr_en;
  logic [1:0]           reg_wr_addr;
  logic [DATA_BITS-1:0] reg_wr_data;
  logic                 reg_rd_en;
  logic [1:0]           reg_rd_addr;
  logic [DATA_BITS-1:0] reg_rd_data;
  logic                 int_req;
  logic                 int_ack;
  logic [2:0]           int_id;

  modport master (
    output reg_wr_en, reg_wr_addr, reg_wr_data,
    output reg_rd_en, reg_rd_addr,
    input  reg_rd_data,
    input  int_req, int_id,
    output int_ack
  );

  modport slave (
    input  reg_wr_en, reg_wr_addr, reg_wr_data,
    input  reg_rd_en, reg_rd_addr,
    output reg_rd_data,
    output int_req, int_id,
    input  int_ack
  );
endinterface

// File: rtl/interrupt_controller.sv
// Fixed-priority interrupt controller: synchronised edge/level sources,
// mask/mode/pending registers, four-phase req/ack toward the core.
module interrupt_controller #(
  parameter int NUM_SOURCES = 4,
  parameter int DATA_BITS   = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_SOURCES-1:0] irq_in,
  interrupt_controller_if.slave  bus
);

  localparam int N = NUM_SOURCES;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] ACK  = 2'd2;

  logic [N-1:0] sync1_q, sync2_q, hist_q;
  logic [N-1:0] pending_q, pending_d;
  logic [N-1:0] mask_q, mask_d;
  logic [N-1:0] mode_q, mode_d;
  logic [1:0]   state_q, state_d;
  logic [2:0]   id_q, id_d;
  logic [DATA_BITS-1:0] rd_q, rd_d;

  logic [N-1:0] rise, enabled, w1c, ack_clr, clr;
  logic [2:0]   win;
  logic         ack_hit;
  logic [DATA_BITS-1:0] mask_x, mode_x, pend_x, stat_x;

  // Lowest enabled index wins
  always_comb begin
    rise    = sync2_q & ~hist_q;
    enabled = pending_q & mask_q;
    win     = 3'd0;
    for (int i = N - 1; i >= 0; i--) begin
      if (enabled[i]) win = 3'(i);
    end
  end

  always_comb begin
    ack_hit = (state_q == REQ) && bus.int_ack;
    w1c     = '0;
    if (bus.reg_wr_en && bus.reg_wr_addr == 2'd2)
      w1c = bus.reg_wr_data[N-1:0];
    for (int i = 0; i < N; i++) begin
      ack_clr[i] = ack_hit && (id_q == 3'(i));
    end
    clr = (w1c | ack_clr) & mode_q;
    // A new edge beats a clear in the same cycle
    pending_d = (mode_q & ((pending_q & ~clr) | rise))
              | (~mode_q & sync2_q);
  end

  always_comb begin
    mask_d = mask_q;
    mode_d = mode_q;
    if (bus.reg_wr_en && bus.reg_wr_addr == 2'd0)
      mask_d = bus.reg_wr_data[N-1:0];
    if (bus.reg_wr_en && bus.reg_wr_addr == 2'd1)
      mode_d = bus.reg_wr_data[N-1:0];
  end

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    case (state_q)
      IDLE: begin
        if (|enabled) begin
          id_d    = win;
          state_d = REQ;
        end
      end
      REQ: begin
        if (bus.int_ack) state_d = ACK;
      end
      ACK: begin
        if (!bus.int_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mask_x         = '0;
    mode_x         = '0;
    pend_x         = '0;
    stat_x         = '0;
    mask_x[N-1:0]  = mask_q;
    mode_x[N-1:0]  = mode_q;
    pend_x[N-1:0]  = pending_q;
    stat_x[4]      = (state_q == REQ);
    stat_x[2:0]    = id_q;
    rd_d           = rd_q;
    if (bus.reg_rd_en) begin
      unique case (bus.reg_rd_addr)
        2'd0: rd_d = mask_x;
        2'd1: rd_d = mode_x;
        2'd2: rd_d = pend_x;
        2'd3: rd_d = stat_x;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      hist_q    <= '0;
      pending_q <= '0;
      mask_q    <= '0;
      mode_q    <= '1;
      state_q   <= IDLE;
      id_q      <= 3'd0;
      rd_q      <= '0;
    end else begin
      sync1_q   <= irq_in;
      sync2_q   <= sync1_q;
      hist_q    <= sync2_q;
      pending_q <= pending_d;
      mask_q    <= mask_d;
      mode_q    <= mode_d;
      state_q   <= state_d;
      id_q      <= id_d;
      rd_q      <= rd_d;
    end
  end

  assign bus.int_req     = (state_q == REQ);
  assign bus.int_id      = id_q;
  assign bus.reg_rd_data = rd_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed bench for interrupt_controller: latency, priority, level,
// masking/W1C, set-wins collision and asynchronous reset.
module tb_interrupt_controller;

  logic       clk;
  logic       reset;
  logic [3:0] irq;

  int n_tests = 0;
  int n_fail  = 0;

  interrupt_controller_if #(.DATA_BITS(8)) bus ();

  interrupt_controller #(
    .NUM_SOURCES(4),
    .DATA_BITS  (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .irq_in(irq),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    bus.reg_wr_en   = 1'b1;
    bus.reg_wr_addr = a;
    bus.reg_wr_data = d;
    tick();
    bus.reg_wr_en   = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [7:0] d);
    bus.reg_rd_en   = 1'b1;
    bus.reg_rd_addr = a;
    tick();
    bus.reg_rd_en   = 1'b0;
    d = bus.reg_rd_data;
  endtask

  task automatic wait_req(input string tag, input int budget);
    int k;
    k = 0;
    while (!bus.int_req && k < budget) begin
      tick();
      k++;
    end
    chk(tag, 32'(bus.int_req), 32'd1);
  endtask

  task automatic handshake(input string tag);
    bus.int_ack = 1'b1;
    tick();
    chk(tag, 32'(bus.int_req), 32'd0);
    bus.int_ack = 1'b0;
    tick();
  endtask

  task automatic pulse(input int b);
    irq[b] = 1'b1;
    ticks(3);
    irq[b] = 1'b0;
  endtask

  logic [7:0] v;

  initial begin
    reset           = 1'b0;
    irq             = '0;
    bus.reg_wr_en   = 1'b0;
    bus.reg_wr_addr = '0;
    bus.reg_wr_data = '0;
    bus.reg_rd_en   = 1'b0;
    bus.reg_rd_addr = '0;
    bus.int_ack     = 1'b0;
    ticks(3);
    reset = 1'b1;
    tick();

    // reset state
    chk("rst_req", 32'(bus.int_req), 32'd0);
    chk("rst_id", 32'(bus.int_id), 32'd0);
    chk("rst_rd", 32'(bus.reg_rd_data), 32'd0);
    rd(2'd0, v); chk("rst_mask", 32'(v), 32'h0);
    rd(2'd1, v); chk("rst_mode", 32'(v), 32'hF);
    rd(2'd2, v); chk("rst_pend", 32'(v), 32'h0);
    rd(2'd3, v); chk("rst_stat", 32'(v), 32'h0);

    // basic edge: request exactly after the 4th edge
    wr(2'd0, 8'h01);
    irq[0] = 1'b1;
    ticks(3);
    chk("edge_early", 32'(bus.int_req), 32'd0);
    irq[0] = 1'b0;
    tick();
    chk("edge_req", 32'(bus.int_req), 32'd1);
    chk("edge_id", 32'(bus.int_id), 32'd0);
    handshake("edge_ack");
    rd(2'd2, v); chk("edge_pend", 32'(v), 32'h0);

    // priority: 1 before 2
    wr(2'd0, 8'h0F);
    irq = 4'b0110;
    ticks(3);
    irq = '0;
    tick();
    chk("pri_req1", 32'(bus.int_req), 32'd1);
    chk("pri_id1", 32'(bus.int_id), 32'd1);
    bus.int_ack = 1'b1;
    tick();
    bus.int_ack = 1'b0;
    tick();
    chk("pri_gap", 32'(bus.int_req), 32'd0);
    tick();
    chk("pri_req2", 32'(bus.int_req), 32'd1);
    chk("pri_id2", 32'(bus.int_id), 32'd2);
    rd(2'd3, v); chk("pri_stat", 32'(v), 32'h12);
    handshake("pri_ack2");
    ticks(4);
    chk("pri_idle", 32'(bus.int_req), 32'd0);
    rd(2'd2, v); chk("pri_pend", 32'(v), 32'h0);

    // level mode on source 3
    wr(2'd1, 8'h00);
    wr(2'd0, 8'h08);
    irq[3] = 1'b1;
    wait_req("lvl_req1", 10);
    chk("lvl_id1", 32'(bus.int_id), 32'd3);
    handshake("lvl_ack1");
    tick();
    chk("lvl_req2", 32'(bus.int_req), 32'd1);
    chk("lvl_id2", 32'(bus.int_id), 32'd3);
    irq[3] = 1'b0;
    ticks(3);
    rd(2'd2, v); chk("lvl_pend", 32'(v), 32'h0);
    handshake("lvl_ack2");
    ticks(5);
    chk("lvl_noreq", 32'(bus.int_req), 32'd0);
    wr(2'd1, 8'h0F);

    // masking and write-1-to-clear
    wr(2'd0, 8'h00);
    pulse(1);
    ticks(3);
    rd(2'd2, v); chk("msk_pend", 32'(v), 32'h2);
    chk("msk_noreq", 32'(bus.int_req), 32'd0);
    wr(2'd2, 8'h02);
    rd(2'd2, v); chk("w1c_pend", 32'(v), 32'h0);
    pulse(1);
    ticks(3);
    wr(2'd0, 8'h02);
    chk("msk_wr_gap", 32'(bus.int_req), 32'd0);
    tick();
    chk("msk_req", 32'(bus.int_req), 32'd1);
    chk("msk_id", 32'(bus.int_id), 32'd1);
    handshake("msk_ack");

    // set-wins: new edge lands on the ack edge
    wr(2'd0, 8'h01);
    pulse(0);
    wait_req("sw_req1", 10);
    ticks(3);
    irq[0] = 1'b1;
    ticks(2);
    bus.int_ack = 1'b1;
    tick();
    irq[0] = 1'b0;
    chk("sw_drop", 32'(bus.int_req), 32'd0);
    bus.int_ack = 1'b0;
    rd(2'd2, v); chk("sw_pend", 32'(v), 32'h1);
    tick();
    chk("sw_req2", 32'(bus.int_req), 32'd1);
    chk("sw_id2", 32'(bus.int_id), 32'd0);
    handshake("sw_ack2");

    // asynchronous reset mid-handshake
    rd(2'd0, v); chk("rs_mask_pre", 32'(v), 32'h1);
    pulse(0);
    wait_req("rs_req", 10);
    #2;
    reset = 1'b0;
    #1;
    chk("rs_req0", 32'(bus.int_req), 32'd0);
    chk("rs_id0", 32'(bus.int_id), 32'd0);
    chk("rs_rd0", 32'(bus.reg_rd_data), 32'd0);
    ticks(2);
    reset = 1'b1;
    tick();
    rd(2'd0, v); chk("rs_mask", 32'(v), 32'h0);
    rd(2'd2, v); chk("rs_pend", 32'(v), 32'h0);
    pulse(0);
    ticks(5);
    chk("rs_noreq", 32'(bus.int_req), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
